priority_encoder_8to3_seq: RTL and testbench

//  Registered 8-to-3 encoder; the inverse of the 3-to-8 one-hot decoder in the lab.

---
 rtl/priority_encoder_8to3_seq.sv | 160 ++++++++++++++++
 tb/tb_priority_encoder_8to3_seq.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_encoder_8to3_seq.sv
// Registered 8-to-3 request encoder: rising edges on a0..a7 become sticky pending bits,
// served one index at a time over a valid/ack handshake. Define ROUND_ROBIN_EN for rotating priority.
module priority_encoder_8to3_seq #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a0,
    input  logic a1,
    input  logic a2,
    input  logic a3,
    input  logic a4,
    input  logic a5,
    input  logic a6,
    input  logic a7,
    input  logic ack,
    output logic z0,
    output logic z1,
    output logic z2,
    output logic valid,
    output logic err
);

    localparam int unsigned N_REQ   = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned CNT_RAW = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned CNT_W   = (ACK_TIMEOUT == 0) ? 4 : ((CNT_RAW < 1) ? 1 : CNT_RAW);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = (ACK_TIMEOUT == 0) ? '0 : CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [N_REQ-1:0]    pending_q, pending_d;
    logic [N_REQ-1:0]    a_prev_q, a_prev_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [IDX_W-1:0]    z_q, z_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    logic [N_REQ-1:0]    a_vec;
    logic [N_REQ-1:0]    rise;
    logic [N_REQ-1:0]    clr;
    logic [IDX_W-1:0]    sel;

    assign a_vec = {a7, a6, a5, a4, a3, a2, a1, a0};
    assign rise  = a_vec & ~a_prev_q;

`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0]    last_q, last_d;
    logic [IDX_W-1:0]    cand;

    // Search last-1 down to last (mod 8); the smallest offset found wins.
    always_comb begin
        sel  = '0;
        cand = '0;
        for (int d = N_REQ; d >= 1; d--) begin
            cand = last_q - IDX_W'(d);
            if (pending_q[cand]) begin
                sel = cand;
            end
        end
    end
`else
    // Fixed priority: highest set index wins.
    always_comb begin
        sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pending_q[i]) begin
                sel = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        z_d      = z_q;
        valid_d  = valid_q;
        err_d    = 1'b0;
        count_d  = count_q;
        clr      = '0;
        a_prev_d = a_vec;
`ifdef ROUND_ROBIN_EN
        last_d   = last_q;
`endif
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (pending_q != '0) begin
                    z_d     = sel;
                    valid_d = 1'b1;
                    count_d = '0;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (ack) begin
                    clr[z_q] = 1'b1;
                    valid_d  = 1'b0;
                    state_d  = IDLE;
`ifdef ROUND_ROBIN_EN
                    last_d   = z_q;
`endif
                end else if ((ACK_TIMEOUT != 0) && (count_q == CNT_LAST)) begin
                    valid_d  = 1'b0;
                    err_d    = 1'b1;
                    state_d  = IDLE;
`ifdef ROUND_ROBIN_EN
                    last_d   = z_q;
`endif
                end else if (count_q != CNT_MAX) begin
                    count_d  = count_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
        // A fresh edge on the served line in the ack cycle re-arms it.
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            a_prev_q  <= '0;
            count_q   <= '0;
            z_q       <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
`ifdef ROUND_ROBIN_EN
            last_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            a_prev_q  <= a_prev_d;
            count_q   <= count_d;
            z_q       <= z_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
`ifdef ROUND_ROBIN_EN
            last_q    <= last_d;
`endif
        end
    end

    assign z0    = z_q[0];
    assign z1    = z_q[1];
    assign z2    = z_q[2];
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: tb/tb_priority_encoder_8to3_seq.sv
// Scenario-task bench for priority_encoder_8to3_seq with a request-set reference model
// and randomized traffic; honours ROUND_ROBIN_EN when defined.
module tb_priority_encoder_8to3_seq;

    localparam int TO = 4;
`ifdef ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a = '0;
    logic       ack = 1'b0;
    logic       z0, z1, z2, valid, err;
    logic [2:0] z;

    int n_tests = 0;
    int n_fail  = 0;

    assign z = {z2, z1, z0};

    priority_encoder_8to3_seq #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .a0(a[0]), .a1(a[1]), .a2(a[2]), .a3(a[3]),
        .a4(a[4]), .a5(a[5]), .a6(a[6]), .a7(a[7]),
        .ack(ack),
        .z0(z0), .z1(z1), .z2(z2), .valid(valid), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: set of pending requests plus the one currently being offered.
    bit [7:0] m_pend, m_prev;
    bit       m_busy, m_valid, m_err;
    bit [2:0] m_z;
    int       m_idx, m_age, m_last;

    function automatic int pick(input bit [7:0] p, input int last);
        if (RR) begin
            for (int d = 1; d <= 8; d++) begin
                if (p[(last + 8 - d) % 8]) return (last + 8 - d) % 8;
            end
        end else begin
            for (int j = 7; j >= 0; j--) begin
                if (p[j]) return j;
            end
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_prev = '0; m_busy = 0; m_valid = 0; m_err = 0;
        m_z = '0; m_idx = 0; m_age = 0; m_last = 0;
    endtask

    task automatic model_step();
        bit [7:0] rise;
        rise  = a & ~m_prev;
        m_err = 0;
        if (m_busy) begin
            if (ack) begin
                m_pend[m_idx] = 1'b0;
                m_busy = 0; m_valid = 0; m_last = m_idx;
            end else if (TO != 0 && m_age == TO - 1) begin
                m_err = 1; m_busy = 0; m_valid = 0; m_last = m_idx;
            end else if (m_age < 15) begin
                m_age++;
            end
        end else if (m_pend != 0) begin
            m_idx = pick(m_pend, m_last);
            m_z = 3'(m_idx); m_valid = 1; m_busy = 1; m_age = 0;
        end
        m_pend = m_pend | rise;
        m_prev = a;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ack   = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        a = 8'h01;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if ({z, valid, err} !== 5'b000_0_0) begin
            n_fail++;
            $display("FAIL reset_outputs: got z=%0d valid=%0b err=%0b, want 0 0 0", z, valid, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        n_tests++;
        if (valid !== 1'b1 || z !== 3'd0 || {z, valid, err} !== {m_z, m_valid, m_err}) begin
            n_fail++;
            $display("FAIL reset_held_line: got z=%0d valid=%0b, want z=0 valid=1", z, valid);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        a = 8'h00;
        step();
    endtask

    task automatic test_single();
        do_reset();
        a = 8'h20;
        step();
        a = 8'h00;
        n_tests++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latency1: got valid=%0b, want 0", valid);
        end
        step();
        n_tests++;
        if (valid !== 1'b1 || z !== 3'd5 || {z, valid, err} !== {m_z, m_valid, m_err}) begin
            n_fail++;
            $display("FAIL single_present: got z=%0d valid=%0b, want z=5 valid=1", z, valid);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (valid !== 1'b0 || err !== 1'b0) begin
                n_fail++;
                $display("FAIL single_cleared: cycle %0d got valid=%0b err=%0b, want 0 0", i, valid, err);
            end
            step();
        end
    endtask

    task automatic test_ack_rise();
        do_reset();
        a = 8'h20;
        step();
        a = 8'h00;
        step();
        step();
        a   = 8'h20;
        ack = 1'b1;
        step();
        a   = 8'h00;
        ack = 1'b0;
        n_tests++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_rise_gap: got valid=%0b, want 0", valid);
        end
        step();
        n_tests++;
        if (valid !== 1'b1 || z !== 3'd5 || {z, valid, err} !== {m_z, m_valid, m_err}) begin
            n_fail++;
            $display("FAIL ack_rise_rearm: got z=%0d valid=%0b, want z=5 valid=1", z, valid);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic test_multi();
        int exp_z [3] = '{7, 6, 2};
        do_reset();
        a = 8'hC4;
        step();
        a = 8'h00;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 10 && valid !== 1'b1; i++) step();
            n_tests++;
            if (valid !== 1'b1 || z !== 3'(exp_z[k]) || z !== m_z) begin
                n_fail++;
                $display("FAIL multi_order: slot %0d got z=%0d valid=%0b, want z=%0d valid=1",
                         k, z, valid, exp_z[k]);
            end
            ack = 1'b1;
            step();
            ack = 1'b0;
            n_tests++;
            if (valid !== 1'b0) begin
                n_fail++;
                $display("FAIL multi_gap: slot %0d got valid=%0b, want 0", k, valid);
            end
            step();
            n_tests++;
            if (valid !== (k < 2 ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL multi_gap_len: slot %0d got valid=%0b, want %0b", k, valid, k < 2);
            end
        end
    endtask

    task automatic test_round_robin();
        int exp_z [4];
        exp_z = RR ? '{6, 1, 6, 1} : '{6, 6, 6, 6};
        do_reset();
        a = 8'h42;
        step();
        a = 8'h00;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 10 && valid !== 1'b1; i++) step();
            n_tests++;
            if (valid !== 1'b1 || z !== 3'(exp_z[k]) || z !== m_z) begin
                n_fail++;
                $display("FAIL rr_order: slot %0d got z=%0d valid=%0b, want z=%0d valid=1",
                         k, z, valid, exp_z[k]);
            end
            ack = 1'b1;
            a   = 8'h42;
            step();
            ack = 1'b0;
            a   = 8'h00;
        end
    endtask

    task automatic test_timeout();
        int hi;
        do_reset();
        a = 8'h08;
        step();
        a = 8'h00;
        step();
        hi = (valid === 1'b1) ? 1 : 0;
        for (int i = 0; i < 20 && valid === 1'b1; i++) begin
            step();
            if (valid === 1'b1) hi++;
        end
        n_tests++;
        if (hi != TO || err !== 1'b1 || {z, valid, err} !== {m_z, m_valid, m_err}) begin
            n_fail++;
            $display("FAIL timeout_len: got high=%0d err=%0b, want high=%0d err=1", hi, err, TO);
        end
        step();
        n_tests++;
        if (err !== 1'b0 || valid !== 1'b1 || z !== 3'd3) begin
            n_fail++;
            $display("FAIL timeout_represent: got z=%0d valid=%0b err=%0b, want z=3 valid=1 err=0",
                     z, valid, err);
        end
        for (int i = 0; i < TO - 1; i++) step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        n_tests++;
        if (valid !== 1'b0 || err !== 1'b0 || {z, valid, err} !== {m_z, m_valid, m_err}) begin
            n_fail++;
            $display("FAIL timeout_ack_wins: got valid=%0b err=%0b, want 0 0", valid, err);
        end
        step();
        step();
        n_tests++;
        if (valid !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_cleared: got valid=%0b err=%0b, want 0 0", valid, err);
        end
    endtask

    task automatic test_level_hold();
        do_reset();
        a = 8'h10;
        step();
        step();
        n_tests++;
        if (valid !== 1'b1 || z !== 3'd4) begin
            n_fail++;
            $display("FAIL level_first: got z=%0d valid=%0b, want z=4 valid=1", z, valid);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (valid !== 1'b0 || {z, valid, err} !== {m_z, m_valid, m_err}) begin
                n_fail++;
                $display("FAIL level_no_edge: cycle %0d got valid=%0b, want 0", i, valid);
            end
            step();
        end
        a = 8'h00;
        step();
        a = 8'h10;
        step();
        step();
        n_tests++;
        if (valid !== 1'b1 || z !== 3'd4) begin
            n_fail++;
            $display("FAIL level_reraise: got z=%0d valid=%0b, want z=4 valid=1", z, valid);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        a = 8'h00;
    endtask

    task automatic test_reset_mid();
        do_reset();
        a = 8'h80;
        step();
        a = 8'h00;
        step();
        n_tests++;
        if (valid !== 1'b1 || z !== 3'd7) begin
            n_fail++;
            $display("FAIL midreset_setup: got z=%0d valid=%0b, want z=7 valid=1", z, valid);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if ({z, valid, err} !== 5'b000_0_0) begin
            n_fail++;
            $display("FAIL midreset_async: got z=%0d valid=%0b err=%0b, want 0 0 0", z, valid, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_tests++;
            if (valid !== 1'b0 || {z, valid, err} !== {m_z, m_valid, m_err}) begin
                n_fail++;
                $display("FAIL midreset_quiet: cycle %0d got z=%0d valid=%0b, want valid=0", i, z, valid);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            a   = a ^ 8'($urandom & $urandom & $urandom);
            ack = ($urandom_range(0, 3) == 0);
            step();
            n_tests++;
            if ({z, valid, err} !== {m_z, m_valid, m_err}) begin
                n_fail++;
                $display("FAIL random_model: cycle %0d got z=%0d valid=%0b err=%0b, want z=%0d valid=%0b err=%0b",
                         i, z, valid, err, m_z, m_valid, m_err);
            end
        end
        ack = 1'b0;
        a   = 8'h00;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_ack_rise();
        test_multi();
        test_round_robin();
        test_timeout();
        test_level_hold();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
